// File: rtl/hazard_scoreboard.sv
// Stall controller for the pipelined MIPS core: scoreboard of pending writes plus MD busy counter.
// Optional HAZARD_STALL_CNT_EN macro adds a 32-bit stall-cycle counter on stall_cnt.
module hazard_scoreboard #(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned WIDTH_T    = 3,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_id,
    input  logic [4:0]         addr_rs_id,
    input  logic [4:0]         addr_rt_id,
    input  logic [WIDTH_T-1:0] tuse_rs_id,
    input  logic [WIDTH_T-1:0] tuse_rt_id,
    input  logic [4:0]         wr_addr_id,
    input  logic [WIDTH_T-1:0] tnew_id,
    input  logic               md_start_id,
    input  logic               md_div_id,
    input  logic               md_use_id,
    output logic               stall_pc,
    output logic               stall_if,
    output logic               clr_ex,
    output logic               md_busy,
    output logic [31:0]        stall_cnt
);

    localparam logic [WIDTH_T-1:0] TUSE_INF = '1;
    localparam int unsigned MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned MD_W   = $clog2(MD_MAX + 1);
    localparam logic [MD_W-1:0] MUL_LOAD = MD_W'(MUL_CYCLES);
    localparam logic [MD_W-1:0] DIV_LOAD = MD_W'(DIV_CYCLES);

    logic [4:0]         sb_addr [NUM_STAGES];
    logic [WIDTH_T-1:0] sb_tnew [NUM_STAGES];
    logic [MD_W-1:0]    md_cnt;
    logic               hz_rs;
    logic               hz_rt;
    logic               stall;
    logic               accept;

    function automatic logic [WIDTH_T-1:0] sat_dec(input logic [WIDTH_T-1:0] v);
        return (v == '0) ? v : v - WIDTH_T'(1);
    endfunction

    // Any matching entry may raise a hazard; younger entries never mask older ones.
    always_comb begin
        hz_rs = 1'b0;
        hz_rt = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (sb_addr[k] != 5'd0 && sb_addr[k] == addr_rs_id &&
                tuse_rs_id != TUSE_INF && sb_tnew[k] > tuse_rs_id) begin
                hz_rs = 1'b1;
            end
            if (sb_addr[k] != 5'd0 && sb_addr[k] == addr_rt_id &&
                tuse_rt_id != TUSE_INF && sb_tnew[k] > tuse_rt_id) begin
                hz_rt = 1'b1;
            end
        end
    end

    assign md_busy  = (md_cnt != '0);
    assign stall    = !reset && valid_id && (hz_rs || hz_rt || (md_use_id && md_busy));
    assign accept   = valid_id && !stall;
    assign stall_pc = stall;
    assign stall_if = stall;
    assign clr_ex   = stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                sb_addr[k] <= 5'd0;
                sb_tnew[k] <= '0;
            end
        end else begin
            sb_addr[0] <= accept ? wr_addr_id : 5'd0;
            sb_tnew[0] <= accept ? sat_dec(tnew_id) : '0;
            for (int k = 1; k < NUM_STAGES; k++) begin
                sb_addr[k] <= sb_addr[k-1];
                sb_tnew[k] <= sat_dec(sb_tnew[k-1]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (accept && md_start_id) begin
            md_cnt <= md_div_id ? DIV_LOAD : MUL_LOAD;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_W'(1);
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
